// File: rtl/bram_snap_pkg.sv
// Shared types and default sizes for the BRAM snapshot writer.
package bram_snap_pkg;

    localparam int unsigned DEPTH_W_DEF = 10;
    localparam int unsigned DATA_W_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/bram_snap_writer.sv
// Captures a burst of streaming samples after a trigger into BRAM port A,
// one word per accepted sample, addresses 0..length, stopping at the last word.
module bram_snap_writer
    import bram_snap_pkg::*;
#(
    parameter int unsigned DEPTH_W = DEPTH_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               trig,
    input  logic               din_valid,
    input  logic [DATA_W-1:0]  din,
    input  logic [DEPTH_W-1:0] length,
    output logic               bram_en_a,
    output logic               bram_we,
    output logic [DEPTH_W-1:0] bram_addr,
    output logic [DATA_W-1:0]  bram_wr_data,
    output logic               busy,
    output logic               done,
    output logic [DEPTH_W:0]   words_written
);

    localparam int unsigned CNT_W = DEPTH_W + 1;

    state_t             r_state;
    logic [DEPTH_W-1:0] r_cnt;
    logic [DEPTH_W-1:0] r_len;

    state_t w_next_state;
    logic   w_accept;
    logic   w_last;
    logic   w_arm_start;

    assign w_accept    = ((r_state == ST_ARMED) && trig && din_valid)
                      || ((r_state == ST_CAPTURE) && din_valid);
    assign w_last      = w_accept && (r_cnt == r_len);
    assign w_arm_start = arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Next-state selection; arm is only honoured from IDLE/DONE (and re-latch in ARMED).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (arm) w_next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_accept) w_next_state = w_last ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_last) w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, counters and registered BRAM port-A drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_len         <= '0;
            bram_en_a     <= 1'b0;
            bram_we       <= 1'b0;
            bram_addr     <= '0;
            bram_wr_data  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
        end else begin
            r_state   <= w_next_state;
            busy      <= (w_next_state == ST_ARMED) || (w_next_state == ST_CAPTURE);
            done      <= (w_next_state == ST_DONE);
            bram_we   <= w_accept;
            bram_en_a <= w_accept;

            if (w_accept) begin
                bram_addr     <= r_cnt;
                bram_wr_data  <= din;
                words_written <= words_written + CNT_W'(1);
                // Hold the counter on the final word so a full-depth capture never wraps.
                if (!w_last) r_cnt <= r_cnt + DEPTH_W'(1);
            end

            if (w_arm_start) begin
                r_len         <= length;
                r_cnt         <= '0;
                words_written <= '0;
            end else if (arm && (r_state == ST_ARMED) && !w_accept) begin
                r_len <= length;
            end
        end
    end

endmodule

// File: tb/tb_bram_snap_writer.sv
// Directed, table-driven bench for bram_snap_writer (DEPTH_W=4 instance).
module tb_bram_snap_writer;

    localparam int unsigned DW = 4;
    localparam int unsigned XW = 32;

    logic          clk;
    logic          rst_n;
    logic          arm;
    logic          trig;
    logic          din_valid;
    logic [XW-1:0] din;
    logic [DW-1:0] length;
    logic          bram_en_a;
    logic          bram_we;
    logic [DW-1:0] bram_addr;
    logic [XW-1:0] bram_wr_data;
    logic          busy;
    logic          done;
    logic [DW:0]   words_written;

    int n_tests = 0;
    int n_fail  = 0;

    bram_snap_writer #(.DEPTH_W(DW), .DATA_W(XW)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arm           (arm),
        .trig          (trig),
        .din_valid     (din_valid),
        .din           (din),
        .length        (length),
        .bram_en_a     (bram_en_a),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_wr_data  (bram_wr_data),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          arm;
        logic          trig;
        logic          dv;
        logic [XW-1:0] din;
        logic [DW-1:0] len;
        logic          we;
        logic [DW-1:0] addr;
        logic [XW-1:0] data;
        logic          busy;
        logic          done;
        logic [DW:0]   ww;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic a, input logic t, input logic v, input logic [XW-1:0] d,
                                input logic [DW-1:0] l, input logic we, input logic [DW-1:0] ad,
                                input logic [XW-1:0] da, input logic bz, input logic dn,
                                input logic [DW:0] ww);
        vec_t r;
        r.arm = a; r.trig = t; r.dv = v; r.din = d; r.len = l;
        r.we = we; r.addr = ad; r.data = da; r.busy = bz; r.done = dn; r.ww = ww;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [XW-1:0] got, input logic [XW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic expect_out(input string nm, input logic we, input logic [DW-1:0] ad,
                              input logic [XW-1:0] da, input logic bz, input logic dn,
                              input logic [DW:0] ww);
        chk({nm, ".we"},   XW'(bram_we),   XW'(we));
        chk({nm, ".en"},   XW'(bram_en_a), XW'(we));
        chk({nm, ".addr"}, XW'(bram_addr), XW'(ad));
        chk({nm, ".data"}, bram_wr_data,   da);
        chk({nm, ".busy"}, XW'(busy),      XW'(bz));
        chk({nm, ".done"}, XW'(done),      XW'(dn));
        chk({nm, ".ww"},   XW'(words_written), XW'(ww));
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic a, input logic t, input logic v, input logic [XW-1:0] d,
                        input logic [DW-1:0] l);
        @(negedge clk);
        arm = a; trig = t; din_valid = v; din = d; length = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; trig = 1'b0; din_valid = 1'b0; din = '0; length = '0;

        // Continuous capture, length 7, trigger three cycles after arm.
        // Non-arm vectors drive length=3 to show the latched value is used.
        tbl.push_back(mk(1, 0, 0, 0, 7, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0));
        for (int n = 0; n < 8; n++)
            tbl.push_back(mk(0, 1, 1, XW'(32'h100 + n), 3, 1, DW'(n), XW'(32'h100 + n),
                             n != 7, n == 7, (DW+1)'(n + 1)));
        tbl.push_back(mk(0, 0, 0, 0, 3, 0, 7, 32'h107, 0, 1, 8));
        // Re-arm from DONE, then din_valid toggling with trig held high.
        tbl.push_back(mk(1, 0, 0, 0, 7, 0, 7, 32'h107, 1, 0, 0));
        for (int n = 0; n < 8; n++) begin
            tbl.push_back(mk(0, 1, 1, XW'(32'h200 + n), 3, 1, DW'(n), XW'(32'h200 + n),
                             n != 7, n == 7, (DW+1)'(n + 1)));
            if (n < 7)
                tbl.push_back(mk(0, 1, 0, 32'hDEAD, 3, 0, DW'(n), XW'(32'h200 + n),
                                 1, 0, (DW+1)'(n + 1)));
        end
        tbl.push_back(mk(0, 1, 1, 32'h999, 3, 0, 7, 32'h207, 0, 1, 8));

        #12;
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].arm, tbl[i].trig, tbl[i].dv, tbl[i].din, tbl[i].len);
            expect_out($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].data,
                       tbl[i].busy, tbl[i].done, tbl[i].ww);
        end

        // arm during CAPTURE is ignored and does not re-latch length.
        step(1, 0, 0, 0, 7);
        expect_out("armcap.arm", 0, 7, 32'h207, 1, 0, 0);
        for (int n = 0; n < 8; n++) begin
            step(n == 2, 1, 1, XW'(32'h300 + n), 1);
            expect_out($sformatf("armcap%0d", n), 1, DW'(n), XW'(32'h300 + n),
                       n != 7, n == 7, (DW+1)'(n + 1));
        end

        // Full-depth capture: 16 words, no wrap.
        step(1, 0, 0, 0, 15);
        expect_out("full.arm", 0, 7, 32'h307, 1, 0, 0);
        for (int n = 0; n < 16; n++) begin
            step(0, 1, 1, XW'(32'h400 + n), 0);
            expect_out($sformatf("full%0d", n), 1, DW'(n), XW'(32'h400 + n),
                       n != 15, n == 15, (DW+1)'(n + 1));
        end
        step(0, 1, 1, 32'h4FF, 0);
        expect_out("full.after", 0, 15, 32'h40F, 0, 1, 16);

        // Asynchronous reset after three writes.
        step(1, 0, 0, 0, 7);
        for (int n = 0; n < 3; n++) begin
            step(0, 1, 1, XW'(32'h500 + n), 7);
            expect_out($sformatf("rst.w%0d", n), 1, DW'(n), XW'(32'h500 + n), 1, 0, (DW+1)'(n + 1));
        end
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst.async", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step(0, 1, 1, XW'(32'h600 + n), 7);
            expect_out($sformatf("rst.post%0d", n), 0, 0, 0, 0, 0, 0);
        end

        // arm and trig together in IDLE: trig not taken until a later cycle.
        step(1, 1, 1, 32'h54, 1);
        expect_out("armtrig.c0", 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 32'h55, 1);
        expect_out("armtrig.c1", 0, 0, 0, 1, 0, 0);
        step(0, 1, 1, 32'h56, 1);
        expect_out("armtrig.c2", 1, 0, 32'h56, 1, 0, 1);
        step(0, 1, 1, 32'h57, 1);
        expect_out("armtrig.c3", 1, 1, 32'h57, 0, 1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
